// File: rtl/booth_cla_pkg.sv
// booth_cla_pkg: shared types, defaults and parameter checks for the pipelined CLA adder.
package booth_cla_pkg;
   localparam int DEF_GROUP = 4;

   typedef struct packed {
      logic p;
      logic g;
   } pg_t;

   function automatic int groups_per_stage(input int width, input int group, input int stages);
      return (group > 0 && stages > 0) ? width / (group * stages) : 1;
   endfunction

   function automatic bit params_ok(input int width, input int group, input int stages);
      return width > 0 && group > 0 && stages > 0 && stages <= width / group &&
             width % (group * stages) == 0;
   endfunction
endpackage

// File: rtl/cla_group_logic.sv
// cla_group_logic: N-bit carry lookahead, per-bit carries from cin plus group propagate/generate.
module cla_group_logic
   import booth_cla_pkg::*;
#(
   parameter int N = DEF_GROUP
) (
   input  logic         cin_i,
   input  logic [N-1:0] p_i,
   input  logic [N-1:0] g_i,
   output logic [N-1:0] c_o,
   output pg_t          pg_o
);
   // gn[i]/pr[i]: generate/propagate of bits [i-1:0] as flat sum-of-products
   logic [N:0] gn, pr;
   logic       term;

   always_comb begin
      gn = '0;
      pr = '0;
      term = 1'b0;
      for (int i = 0; i <= N; i++) begin
         pr[i] = 1'b1;
         for (int j = 0; j < i; j++) begin
            term = g_i[j];
            for (int m = j + 1; m < i; m++) term = term & p_i[m];
            gn[i] = gn[i] | term;
            pr[i] = pr[i] & p_i[j];
         end
      end
   end

   assign c_o = gn[N-1:0] | (pr[N-1:0] & {N{cin_i}});
   assign pg_o = '{p: pr[N], g: gn[N]};
endmodule

// File: rtl/pipe_cla_adder.sv
// pipe_cla_adder: pipelined carry-lookahead adder/subtractor with valid/ready backpressure.
// Define PIPE_CLA_OVF_EN to build the registered signed-overflow output; otherwise ovf is 0.
module pipe_cla_adder
   import booth_cla_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int GROUP  = DEF_GROUP,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int SW = WIDTH / STAGES;
   localparam int NG = groups_per_stage(WIDTH, GROUP, STAGES);

   if (!params_ok(WIDTH, GROUP, STAGES)) begin : g_bad_params
      $error("pipe_cla_adder: WIDTH must be a multiple of GROUP*STAGES");
   end

   // a/b' are kept shifted so the next slice is always at bit 0; sum slices enter from the top
   logic [WIDTH-1:0]  a_q [STAGES], bp_q [STAGES], s_q [STAGES];
   logic [WIDTH-1:0]  a_d [STAGES], bp_d [STAGES], s_d [STAGES];
   logic [WIDTH-1:0]  a_x [STAGES], bp_x [STAGES], s_x [STAGES];
   logic [STAGES-1:0] v_q, v_d, c_q, c_d, c_x, ld;
`ifdef PIPE_CLA_OVF_EN
   logic              ovf_q, ovf_d;
`endif

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [SW-1:0] p, g, cv;
      logic [NG:0]   sp, sg, gc;
      pg_t           gpg [NG];
      logic          term;
      if (k == 0) begin : g_first
         assign a_x[k]  = a;
         assign bp_x[k] = sub ? ~b : b;
         assign s_x[k]  = '0;
         assign c_x[k]  = sub | cin;
         assign v_d[k]  = in_valid;
      end else begin : g_next
         assign a_x[k]  = a_q[k-1];
         assign bp_x[k] = bp_q[k-1];
         assign s_x[k]  = s_q[k-1];
         assign c_x[k]  = c_q[k-1];
         assign v_d[k]  = v_q[k-1];
      end
      assign p = a_x[k][SW-1:0] ^ bp_x[k][SW-1:0];
      assign g = a_x[k][SW-1:0] & bp_x[k][SW-1:0];
      for (genvar j = 0; j < NG; j++) begin : g_grp
         cla_group_logic #(.N(GROUP)) u_grp (
            .cin_i(gc[j]),
            .p_i  (p[j*GROUP +: GROUP]),
            .g_i  (g[j*GROUP +: GROUP]),
            .c_o  (cv[j*GROUP +: GROUP]),
            .pg_o (gpg[j])
         );
      end
      // second-level lookahead: group carry-ins straight from the stage carry-in
      always_comb begin
         sg = '0;
         sp = '0;
         term = 1'b0;
         for (int i = 0; i <= NG; i++) begin
            sp[i] = 1'b1;
            for (int j = 0; j < i; j++) begin
               term = gpg[j].g;
               for (int m = j + 1; m < i; m++) term = term & gpg[m].p;
               sg[i] = sg[i] | term;
               sp[i] = sp[i] & gpg[j].p;
            end
         end
      end
      assign gc      = sg | (sp & {(NG + 1){c_x[k]}});
      assign a_d[k]  = a_x[k] >> SW;
      assign bp_d[k] = bp_x[k] >> SW;
      assign s_d[k]  = WIDTH'({p ^ cv, s_x[k]} >> SW);
      assign c_d[k]  = gc[NG];
`ifdef PIPE_CLA_OVF_EN
      if (k == STAGES - 1) begin : g_ovf
         assign ovf_d = cv[SW-1] ^ gc[NG];
      end
`endif
   end

   always_comb begin
      ld = '0;
      ld[STAGES-1] = ~v_q[STAGES-1] | out_ready;
      for (int k = STAGES - 2; k >= 0; k--) ld[k] = ~v_q[k] | ld[k+1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= '0;
         c_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]  <= '0;
            bp_q[k] <= '0;
            s_q[k]  <= '0;
         end
`ifdef PIPE_CLA_OVF_EN
         ovf_q <= 1'b0;
`endif
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (ld[k]) v_q[k] <= v_d[k];
            if (ld[k] && v_d[k]) begin
               a_q[k]  <= a_d[k];
               bp_q[k] <= bp_d[k];
               s_q[k]  <= s_d[k];
               c_q[k]  <= c_d[k];
            end
         end
`ifdef PIPE_CLA_OVF_EN
         if (ld[STAGES-1] && v_d[STAGES-1]) ovf_q <= ovf_d;
`endif
      end
   end

   assign in_ready  = ld[0];
   assign out_valid = v_q[STAGES-1];
   assign sum       = s_q[STAGES-1];
   assign cout      = c_q[STAGES-1];
`ifdef PIPE_CLA_OVF_EN
   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_cla_adder.sv
// tb_pipe_cla_adder: directed checks of pipe_cla_adder (WIDTH=32, GROUP=4, STAGES=2) plus a
// short randomised handshake run against a behavioural a+b / a-b model.
module tb_pipe_cla_adder;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0;
   logic        out_valid, out_ready = 1'b0, cout, ovf;
   logic [31:0] a = '0, b = '0, sum;
   int          n_cmp = 0, n_bad = 0;
`ifdef PIPE_CLA_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   always #5 clk = ~clk;

   pipe_cla_adder #(.WIDTH(32), .GROUP(4), .STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tc, input logic ts);
      a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
      for (int i = 0; i < 20 && !in_ready; i++) tick;
      chk("send_ready", in_ready, 1);
      tick;
      in_valid = 1'b0;
   endtask

   task automatic expect_out(input string tag, input logic [31:0] es, input logic ec, input logic eo);
      for (int i = 0; i < 20 && !out_valid; i++) tick;
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_sum"}, sum, es);
      chk({tag, "_cout"}, cout, ec);
      chk({tag, "_ovf"}, ovf, eo);
      tick;
   endtask

   function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                         input logic mc, input logic ms);
      logic [31:0] bp;
      logic [32:0] r;
      logic        ov;
      bp = ms ? ~mb : mb;
      r  = {1'b0, ma} + {1'b0, bp} + 33'(ms | mc);
      ov = OVF_ON & (ma[31] == bp[31]) & (r[31] != ma[31]);
      return {r[32], ov, r[31:0]};
   endfunction

   logic [31:0] bp_a [4] = '{32'd1, 32'd10, 32'hFFFF0000, 32'd100};
   logic [31:0] bp_b [4] = '{32'd2, 32'd20, 32'h00010000, 32'd1};
   logic        bp_m [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
   logic [31:0] bp_s [4] = '{32'd3, 32'd30, 32'h00000000, 32'd99};
   logic        bp_c [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
   logic [33:0] q [$];

   initial begin
      int  acc, got, seen, sent;
      bit  took;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);
      #20 rst_n = 1'b1;
      tick;
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_out_valid", out_valid, 0);
      out_ready = 1'b1;

      // latency: accepted at edge N, valid after edge N+1
      a = 32'hFFFFFFFF; b = 32'h1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      chk("lat_not_yet", out_valid, 0);
      tick;
      chk("lat_valid", out_valid, 1);
      chk("wrap_sum", sum, 32'h0);
      chk("wrap_cout", cout, 1);
      chk("wrap_ovf", ovf, 0);
      tick;
      chk("lat_consumed", out_valid, 0);

      send(32'd5, 32'd7, 1'b0, 1'b1);                 expect_out("sub_neg", 32'hFFFFFFFE, 1'b0, 1'b0);
      send(32'd7, 32'd5, 1'b0, 1'b1);                 expect_out("sub_pos", 32'd2, 1'b1, 1'b0);
      send(32'h7FFFFFFF, 32'd1, 1'b0, 1'b0);          expect_out("ovf_add", 32'h80000000, 1'b0, OVF_ON);
      send(32'h80000000, 32'd1, 1'b0, 1'b1);          expect_out("ovf_sub", 32'h7FFFFFFF, 1'b1, OVF_ON);
      send(32'h80000000, 32'h80000000, 1'b0, 1'b0);   expect_out("ovf_neg", 32'h0, 1'b1, OVF_ON);
      send(32'h0000FFFF, 32'd1, 1'b0, 1'b0);          expect_out("stage_cross", 32'h00010000, 1'b0, 1'b0);
      send(32'h000000FF, 32'd1, 1'b0, 1'b0);          expect_out("group_cross", 32'h00000100, 1'b0, 1'b0);
      send(32'hFFFFFFFF, 32'd0, 1'b1, 1'b0);          expect_out("cin_wrap", 32'h0, 1'b1, 1'b0);
      send(32'd10, 32'd3, 1'b1, 1'b1);                expect_out("sub_cin_ign", 32'd7, 1'b1, 1'b0);
      send(32'd0, 32'd0, 1'b0, 1'b1);                 expect_out("sub_zero", 32'd0, 1'b1, 1'b0);
      send(32'h12345678, 32'h0FEDCBA9, 1'b1, 1'b0);   expect_out("mixed", 32'h22222222, 1'b0, 1'b0);

      // backpressure: pipe holds two ops, then drains one per cycle in order
      out_ready = 1'b0;
      acc = 0;
      in_valid = 1'b1;
      for (int cyc = 0; cyc < 4; cyc++) begin
         a = bp_a[acc]; b = bp_b[acc]; sub = bp_m[acc]; cin = 1'b0;
         @(negedge clk);
         took = in_ready;
         tick;
         if (took) acc++;
      end
      chk("bp_accepted", acc, 2);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_head", sum, bp_s[0]);
      tick;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_sum", sum, bp_s[0]);
      out_ready = 1'b1;
      got = 0;
      for (int cyc = 0; cyc < 4; cyc++) begin
         if (acc < 4) begin
            a = bp_a[acc]; b = bp_b[acc]; sub = bp_m[acc]; in_valid = 1'b1;
         end else in_valid = 1'b0;
         @(negedge clk);
         took = in_ready && in_valid;
         chk($sformatf("bp_out%0d_valid", cyc), out_valid, 1);
         chk($sformatf("bp_out%0d_sum", cyc), sum, bp_s[got]);
         chk($sformatf("bp_out%0d_cout", cyc), cout, bp_c[got]);
         got++;
         tick;
         if (took) acc++;
      end
      in_valid = 1'b0;
      chk("bp_all_accepted", acc, 4);
      chk("bp_drained", out_valid, 0);

      // asynchronous reset with a full pipe
      out_ready = 1'b0;
      send(32'd3, 32'd4, 1'b0, 1'b0);
      send(32'h11111111, 32'd1, 1'b0, 1'b0);
      chk("mid_full", out_valid, 1);
      chk("mid_sum_before", sum, 32'd7);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_sum", sum, 0);
      chk("mid_rst_cout", cout, 0);
      tick;
      tick;
      rst_n = 1'b1;
      chk("mid_rel_in_ready", in_ready, 1);
      out_ready = 1'b1;
      seen = 0;
      for (int cyc = 0; cyc < 4; cyc++) begin
         @(negedge clk);
         if (out_valid) seen++;
         tick;
      end
      chk("mid_no_stale", seen, 0);

      // randomised traffic with random backpressure
      sent = 0;
      for (int cyc = 0; cyc < 3000 && (sent < 400 || q.size() > 0); cyc++) begin
         in_valid  = (sent < 400) && ($urandom_range(0, 3) != 0);
         a         = $urandom;
         b         = $urandom;
         cin       = 1'($urandom_range(0, 1));
         sub       = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         if (in_valid && in_ready) begin
            q.push_back(model(a, b, cin, sub));
            sent++;
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) chk("rnd_spurious", out_valid, 0);
            else chk("rnd_result", {cout, ovf, sum}, q.pop_front());
         end
         tick;
      end
      in_valid = 1'b0;
      chk("rnd_sent", sent, 400);
      chk("rnd_drained", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
